// File: rtl/stack_pkg.sv
// Shared definitions for the tinycpu stack sequencer: data width,
// opcode encodings, FSM state encoding and the single-cycle ALU.
package stack_pkg;

  localparam int W = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_DUP  = 4'd2;
  localparam logic [3:0] OP_DROP = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SWAP = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWAP2,
    ST_MUL_RUN,
    ST_MUL_WB
  } state_e;

  // Binary op result: next-of-stack OP top-of-stack, carry discarded.
  function automatic logic [W-1:0] alu_result(input logic [3:0]   op,
                                              input logic [W-1:0] nos,
                                              input logic [W-1:0] tos);
    case (op)
      OP_ADD:  return nos + tos;
      OP_SUB:  return nos - tos;
      OP_AND:  return nos & tos;
      OP_OR:   return nos | tos;
      OP_XOR:  return nos ^ tos;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/stack_mul.sv
// Iterative 16x16 shift-add multiplier keeping the low 16 bits of the
// product. One multiplier bit per cycle, LSB first, 16 cycles per product.
module stack_mul
  import stack_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         last_o,
  output logic [W-1:0] result_o
);

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] acc_q;
  logic [3:0]   cnt_q;
  logic         busy_q;

  // Latch operands on start, then add the shifted multiplicand per set bit.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_q + (b_q[0] ? a_q : '0);
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) busy_q <= 1'b0;
    end
  end

  assign busy_o   = busy_q;
  assign last_o   = busy_q && (cnt_q == 4'd15);
  assign result_o = acc_q;

endmodule

// File: rtl/stack_ctrl.sv
// Stack-machine sequencer: accepts opcodes over valid/ready, drives the
// shift-register stack strobes, tracks depth and rejects ops that would
// underflow or overflow. SWAP and MUL are sequenced by a small FSM.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [3:0]               op,
  input  logic [W-1:0]             imm,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(N+1)-1:0]   depth,
  output logic                     load,
  output logic                     push,
  output logic                     pop,
  output logic [W-1:0]             d,
  input  logic [W-1:0]             qtop,
  input  logic [W-1:0]             qnext
);

  localparam int             DW        = $clog2(N + 1);
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(N);
  localparam logic [DW-1:0]  ONE       = DW'(1);
  localparam logic [DW-1:0]  TWO       = DW'(2);

  state_e        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [W-1:0]  t_q, t_d;
  logic          op_ok;
  logic          mul_start;
  logic          mul_busy;
  logic          mul_last;
  logic [W-1:0]  mul_result;

  stack_mul u_mul (
    .clk      (clk),
    .rst_n    (reset),
    .start_i  (mul_start),
    .a_i      (qnext),
    .b_i      (qtop),
    .busy_o   (mul_busy),
    .last_o   (mul_last),
    .result_o (mul_result)
  );

  assign op_ready = (state_q == ST_IDLE);
  assign depth    = depth_q;

  // Depth legality of the offered opcode; illegal encodings are never ok.
  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_NOP:  op_ok = 1'b1;
      OP_PUSH: op_ok = (depth_q < DEPTH_MAX);
      OP_DUP:  op_ok = (depth_q < DEPTH_MAX) && (depth_q != '0);
      OP_DROP: op_ok = (depth_q != '0);
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SWAP, OP_MUL:
               op_ok = (depth_q >= TWO);
      default: op_ok = 1'b0;
    endcase
  end

  // Strobe decode and next-state logic for the sequencer.
  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    t_d       = t_q;
    load      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    d         = '0;
    done      = 1'b0;
    err       = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (!op_ok) begin
            err = 1'b1;
          end else begin
            case (op)
              OP_NOP: done = 1'b1;
              OP_PUSH: begin
                push    = 1'b1;
                load    = 1'b1;
                d       = imm;
                done    = 1'b1;
                depth_d = depth_q + ONE;
              end
              OP_DUP: begin
                push    = 1'b1;
                done    = 1'b1;
                depth_d = depth_q + ONE;
              end
              OP_DROP: begin
                pop     = 1'b1;
                done    = 1'b1;
                depth_d = depth_q - ONE;
              end
              OP_SWAP: begin
                pop     = 1'b1;
                t_d     = qtop;
                state_d = ST_SWAP2;
              end
              OP_MUL: begin
                mul_start = 1'b1;
                state_d   = ST_MUL_RUN;
              end
              default: begin
                load    = 1'b1;
                pop     = 1'b1;
                d       = alu_result(op, qnext, qtop);
                done    = 1'b1;
                depth_d = depth_q - ONE;
              end
            endcase
          end
        end
      end
      ST_SWAP2: begin
        push    = 1'b1;
        load    = 1'b1;
        d       = t_q;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_MUL_RUN: begin
        if (mul_last)      state_d = ST_MUL_WB;
        else if (!mul_busy) state_d = ST_IDLE;  // recover if the multiplier idles unexpectedly
      end
      ST_MUL_WB: begin
        load    = 1'b1;
        pop     = 1'b1;
        d       = mul_result;
        done    = 1'b1;
        depth_d = depth_q - ONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, depth counter and SWAP latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      depth_q <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      t_q     <= t_d;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl with a behavioural shift-register stack.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int N  = 8;
  localparam int DW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [3:0]    op = '0;
  logic [W-1:0]  imm = '0;
  logic          done, err;
  logic [DW-1:0] depth;
  logic          load, push, pop;
  logic [W-1:0]  d;
  logic [W-1:0]  qtop, qnext;

  logic [W-1:0]  stk [N];

  typedef struct {
    string        name;
    logic         is_err;
    logic [2:0]   strb;     // {load, push, pop}
    logic [W-1:0] d;
    logic [DW-1:0] depth_after;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic          dchk_pend = 1'b0;
  logic [DW-1:0] dchk_val;
  string         dchk_name;

  stack_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .imm(imm), .done(done), .err(err), .depth(depth),
    .load(load), .push(push), .pop(pop), .d(d), .qtop(qtop), .qnext(qnext)
  );

  always #5 clk = ~clk;

  // Attached stack: entry 0 is the top; push shifts down, pop shifts up.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) stk[i] <= '0;
    end else if (pop) begin
      for (int i = 1; i < N - 1; i++) stk[i] <= stk[i+1];
      stk[N-1] <= '0;
      stk[0]   <= load ? d : stk[1];
    end else if (push) begin
      for (int i = 1; i < N; i++) stk[i] <= stk[i-1];
      stk[0] <= load ? d : stk[0];
    end else if (load) begin
      stk[0] <= d;
    end
  end
  assign qtop  = stk[0];
  assign qnext = stk[1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic expect_op(input string name, input logic is_err, input logic [2:0] strb,
                           input logic [W-1:0] dv, input int dep);
    exp_t e;
    e.name = name; e.is_err = is_err; e.strb = strb; e.d = dv;
    e.depth_after = DW'(dep);
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per done/err pulse, checks depth one cycle later.
  always @(negedge clk) begin
    if (!reset) begin
      dchk_pend = 1'b0;
    end else begin
      if (dchk_pend) begin
        check({dchk_name, "_depth"}, 32'(depth), 32'(dchk_val));
        dchk_pend = 1'b0;
      end
      if (done || err) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_response: got done=%0b err=%0b, want no response", done, err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_done_err"}, {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
          check({e.name, "_strobes"}, {29'd0, load, push, pop}, {29'd0, e.strb});
          if (e.strb[2]) check({e.name, "_d"}, 32'(d), 32'(e.d));
          dchk_pend = 1'b1;
          dchk_val  = e.depth_after;
          dchk_name = e.name;
        end
      end
    end
  end

  // Offer one opcode, return the strobes seen in its accept cycle.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] v, output logic [2:0] strb);
    int w = 0;
    @(posedge clk); #1;
    while (!op_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!op_ready) check("ready_timeout", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op = o; imm = v;
    @(negedge clk);
    strb = {load, push, pop};
    @(posedge clk); #1;
    op_valid = 1'b0; op = 4'd15; imm = 16'hDEAD;
  endtask

  task automatic do_op(input string name, input logic [3:0] o, input logic [W-1:0] v,
                       input logic is_err, input logic [2:0] strb, input logic [W-1:0] dv,
                       input int dep);
    logic [2:0] s;
    expect_op(name, is_err, strb, dv, dep);
    issue(o, v, s);
  endtask

  // Count op_ready-low cycles and the cycle of done after a multi-cycle accept.
  task automatic measure(input string nm, input int want_low, input int want_done);
    int low = 0, dc = -1, c = 1;
    bit fin = 1'b0;
    while (!fin && c < 40) begin
      @(negedge clk);
      if (!op_ready) low++;
      if (done) dc = c;
      if (op_ready) fin = 1'b1;
      else begin @(posedge clk); #1; c++; end
    end
    check({nm, "_ready_low_cycles"}, 32'(low), 32'(want_low));
    check({nm, "_done_cycle"}, 32'(dc), 32'(want_done));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_strobes", {29'd0, load, push, pop}, 32'd0);
    check("rst_d", 32'(d), 32'd0);
    reset = 1'b1;

    // PUSH 5, PUSH 3, ADD
    do_op("push5", OP_PUSH, 16'd5, 1'b0, 3'b110, 16'd5, 1);
    do_op("push3", OP_PUSH, 16'd3, 1'b0, 3'b110, 16'd3, 2);
    do_op("add",   OP_ADD,  16'd0, 1'b0, 3'b101, 16'd8, 1);
    check("add_qtop", 32'(qtop), 32'd8);
    check("add_depth", 32'(depth), 32'd1);

    // SUB is next-of-stack minus top-of-stack, wrapping
    do_op("push10", OP_PUSH, 16'd10, 1'b0, 3'b110, 16'd10, 2);
    do_op("push3b", OP_PUSH, 16'd3,  1'b0, 3'b110, 16'd3,  3);
    do_op("sub1",   OP_SUB,  16'd0,  1'b0, 3'b101, 16'd7,  2);
    check("sub1_qtop", 32'(qtop), 32'd7);
    do_op("push9",  OP_PUSH, 16'd9,  1'b0, 3'b110, 16'd9,  3);
    do_op("sub2",   OP_SUB,  16'd0,  1'b0, 3'b101, 16'hFFFE, 2);
    check("sub2_qtop", 32'(qtop), 32'hFFFE);
    check("sub2_qnext", 32'(qnext), 32'd8);
    do_op("drop_a", OP_DROP, 16'd0, 1'b0, 3'b001, 16'd0, 1);
    do_op("drop_b", OP_DROP, 16'd0, 1'b0, 3'b001, 16'd0, 0);

    // SWAP: pop in accept cycle, push+load of latched top one cycle later
    do_op("push1", OP_PUSH, 16'd1, 1'b0, 3'b110, 16'd1, 1);
    do_op("push2", OP_PUSH, 16'd2, 1'b0, 3'b110, 16'd2, 2);
    do_op("push3c", OP_PUSH, 16'd3, 1'b0, 3'b110, 16'd3, 3);
    expect_op("swap", 1'b0, 3'b110, 16'd3, 3);
    issue(OP_SWAP, 16'd0, s);
    check("swap_accept_strobes", 32'(s), 32'b001);
    measure("swap", 1, 1);
    check("swap_depth", 32'(depth), 32'd3);
    do_op("drop_c", OP_DROP, 16'd0, 1'b0, 3'b001, 16'd0, 2);
    do_op("drop_d", OP_DROP, 16'd0, 1'b0, 3'b001, 16'd0, 1);
    do_op("drop_e", OP_DROP, 16'd0, 1'b0, 3'b001, 16'd0, 0);

    // MUL 0x0123 * 0x0100 -> 0x2300
    do_op("push_m1", OP_PUSH, 16'h0123, 1'b0, 3'b110, 16'h0123, 1);
    do_op("push_m2", OP_PUSH, 16'h0100, 1'b0, 3'b110, 16'h0100, 2);
    expect_op("mul1", 1'b0, 3'b101, 16'h2300, 1);
    issue(OP_MUL, 16'd0, s);
    check("mul1_accept_strobes", 32'(s), 32'b000);
    measure("mul1", 17, 17);
    check("mul1_qtop", 32'(qtop), 32'h2300);
    check("mul1_depth", 32'(depth), 32'd1);

    // MUL 0xFFFF * 0xFFFF -> low half 0x0001 (exercises the top multiplier bit)
    do_op("push_m3", OP_PUSH, 16'hFFFF, 1'b0, 3'b110, 16'hFFFF, 2);
    do_op("push_m4", OP_PUSH, 16'hFFFF, 1'b0, 3'b110, 16'hFFFF, 3);
    expect_op("mul2", 1'b0, 3'b101, 16'h0001, 2);
    issue(OP_MUL, 16'd0, s);
    measure("mul2", 17, 17);
    check("mul2_qnext", 32'(qnext), 32'h2300);
    do_op("drop_f", OP_DROP, 16'd0, 1'b0, 3'b001, 16'd0, 1);
    do_op("drop_g", OP_DROP, 16'd0, 1'b0, 3'b001, 16'd0, 0);

    // Underflow on the empty stack
    do_op("drop_empty", OP_DROP, 16'd0, 1'b1, 3'b000, 16'd0, 0);
    do_op("add_empty",  OP_ADD,  16'd0, 1'b1, 3'b000, 16'd0, 0);
    do_op("dup_empty",  OP_DUP,  16'd0, 1'b1, 3'b000, 16'd0, 0);
    do_op("mul_empty",  OP_MUL,  16'd0, 1'b1, 3'b000, 16'd0, 0);

    // Fill to N, then overflow
    for (int i = 1; i <= N; i++)
      do_op($sformatf("fill%0d", i), OP_PUSH, 16'(i), 1'b0, 3'b110, 16'(i), i);
    do_op("push_full", OP_PUSH, 16'h77, 1'b1, 3'b000, 16'd0, N);
    do_op("dup_full",  OP_DUP,  16'd0,  1'b1, 3'b000, 16'd0, N);
    do_op("op12",      4'd12,   16'd0,  1'b1, 3'b000, 16'd0, N);
    check("full_qtop", 32'(qtop), 32'd8);

    // Remaining ALU ops on the full stack: 7&8=0, 6|0=6, 5^6=3
    do_op("and", OP_AND, 16'd0, 1'b0, 3'b101, 16'd0, 7);
    do_op("or",  OP_OR,  16'd0, 1'b0, 3'b101, 16'd6, 6);
    do_op("xor", OP_XOR, 16'd0, 1'b0, 3'b101, 16'd3, 5);
    do_op("nop", OP_NOP, 16'd0, 1'b0, 3'b000, 16'd0, 5);
    do_op("op15", 4'd15, 16'd0, 1'b1, 3'b000, 16'd0, 5);
    check("xor_qtop", 32'(qtop), 32'd3);
    check("xor_qnext", 32'(qnext), 32'd4);

    // Reset in MUL_RUN cycle 8: no write-back, no done
    issue(OP_MUL, 16'd0, s);
    repeat (7) @(posedge clk);
    #1;
    check("mrst_busy_before", 32'(op_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mrst_ready", 32'(op_ready), 32'd1);
    check("mrst_depth", 32'(depth), 32'd0);
    check("mrst_strobes", {29'd0, load, push, pop}, 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("mrst_depth_after", 32'(depth), 32'd0);
    check("mrst_ready_after", 32'(op_ready), 32'd1);
    do_op("push_post", OP_PUSH, 16'h55, 1'b0, 3'b110, 16'h55, 1);
    check("post_qtop", 32'(qtop), 32'h55);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
